// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - shares one ROM/SDRAM read port between CPU PRG and PPU CHR fetches
// Optional SDRAM refresh slot enabled by defining ROMARB_REFRESH_EN.
module rom_port_arbiter #(
    parameter int STARVE_MAX       = 4,
    parameter int REFRESH_INTERVAL = 384
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic [16:0] cpu_addr,
    output logic        cpu_ack,
    output logic [7:0]  cpu_data,
    input  logic        ppu_req,
    input  logic [16:0] ppu_addr,
    output logic        ppu_ack,
    output logic [7:0]  ppu_data,
    output logic        mem_req,
    output logic [17:0] mem_addr,
    output logic        mem_refresh,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        proto_err
);

`ifdef ROMARB_REFRESH_EN
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_REFRESH = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1
    } state_t;
`endif

    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    state_t      r_state;
    state_t      w_next;

    logic        r_cpu_pend;
    logic        r_ppu_pend;
    logic [16:0] r_cpu_addr;
    logic [16:0] r_ppu_addr;
    logic [3:0]  r_starve;
    logic        r_win_cpu;
    logic        r_mem_req;
    logic [17:0] r_mem_addr;
    logic        r_cpu_ack;
    logic        r_ppu_ack;
    logic [7:0]  r_cpu_data;
    logic [7:0]  r_ppu_data;
    logic        r_proto_err;

    logic        w_grant_cpu;
    logic        w_grant_ppu;
    logic        w_grant_ref;
    logic        w_done;
    logic        w_ref_pend;
    logic        w_starved;
    logic        w_cpu_busy;
    logic        w_ppu_busy;
    logic        w_cpu_accept;
    logic        w_ppu_accept;

    assign w_starved = (r_starve == LP_STARVE_MAX);

    // A source is free again on the edge its transaction completes, so a
    // request arriving together with the memory ack is accepted.
    assign w_cpu_busy = r_cpu_pend |
                        ((r_state == S_BUSY) && r_win_cpu && !mem_ack);
    assign w_ppu_busy = r_ppu_pend |
                        ((r_state == S_BUSY) && !r_win_cpu && !mem_ack);

    assign w_cpu_accept = cpu_req && !w_cpu_busy;
    assign w_ppu_accept = ppu_req && !w_ppu_busy;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_grant_cpu = 1'b0;
        w_grant_ppu = 1'b0;
        w_grant_ref = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ref_pend) begin
                    w_grant_ref = 1'b1;
                end else if (r_cpu_pend && w_starved) begin
                    w_grant_cpu = 1'b1;
                end else if (r_ppu_pend) begin
                    w_grant_ppu = 1'b1;
                end else if (r_cpu_pend) begin
                    w_grant_cpu = 1'b1;
                end
                if (w_grant_cpu || w_grant_ppu) begin
                    w_next = S_BUSY;
                end
`ifdef ROMARB_REFRESH_EN
                if (w_grant_ref) begin
                    w_next = S_REFRESH;
                end
`endif
            end
            S_BUSY: begin
                if (mem_ack) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
`ifdef ROMARB_REFRESH_EN
            S_REFRESH: begin
                if (mem_ack) begin
                    w_next = S_IDLE;
                end
            end
`endif
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cpu_pend  <= 1'b0;
            r_ppu_pend  <= 1'b0;
            r_cpu_addr  <= 17'd0;
            r_ppu_addr  <= 17'd0;
            r_proto_err <= 1'b0;
        end else begin
            r_cpu_pend <= (r_cpu_pend & ~w_grant_cpu) | w_cpu_accept;
            r_ppu_pend <= (r_ppu_pend & ~w_grant_ppu) | w_ppu_accept;
            if (w_cpu_accept) begin
                r_cpu_addr <= cpu_addr;
            end
            if (w_ppu_accept) begin
                r_ppu_addr <= ppu_addr;
            end
            if ((cpu_req && w_cpu_busy) || (ppu_req && w_ppu_busy)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // Starvation only accumulates while the CPU is actually waiting.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_starve <= 4'd0;
        end else if (w_grant_cpu) begin
            r_starve <= 4'd0;
        end else if (w_grant_ppu && r_cpu_pend) begin
            if (!w_starved) begin
                r_starve <= r_starve + 4'd1;
            end
        end else if ((w_grant_ppu || w_grant_ref) && !r_cpu_pend) begin
            r_starve <= 4'd0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= 18'd0;
            r_win_cpu  <= 1'b0;
            r_cpu_ack  <= 1'b0;
            r_ppu_ack  <= 1'b0;
            r_cpu_data <= 8'h00;
            r_ppu_data <= 8'h00;
        end else begin
            r_cpu_ack <= 1'b0;
            r_ppu_ack <= 1'b0;
            if (w_grant_cpu) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= {1'b0, r_cpu_addr};
                r_win_cpu  <= 1'b1;
            end else if (w_grant_ppu) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= {1'b1, r_ppu_addr};
                r_win_cpu  <= 1'b0;
            end else if (w_done) begin
                r_mem_req <= 1'b0;
                if (r_win_cpu) begin
                    r_cpu_data <= mem_rdata;
                    r_cpu_ack  <= 1'b1;
                end else begin
                    r_ppu_data <= mem_rdata;
                    r_ppu_ack  <= 1'b1;
                end
            end
        end
    end

`ifdef ROMARB_REFRESH_EN
    localparam int LP_REF_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [LP_REF_W-1:0] LP_REF_LAST = LP_REF_W'(REFRESH_INTERVAL - 1);

    logic [LP_REF_W-1:0] r_ref_cnt;
    logic                r_ref_pend;
    logic                r_mem_refresh;
    logic                w_ref_wrap;

    assign w_ref_wrap = (r_ref_cnt == LP_REF_LAST);
    assign w_ref_pend = r_ref_pend;

    // A wrap while a refresh is still pending merges into that one.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ref_cnt     <= '0;
            r_ref_pend    <= 1'b0;
            r_mem_refresh <= 1'b0;
        end else begin
            r_ref_cnt  <= w_ref_wrap ? '0 : r_ref_cnt + 1'b1;
            r_ref_pend <= w_ref_wrap | (r_ref_pend & ~w_grant_ref);
            if (w_grant_ref) begin
                r_mem_refresh <= 1'b1;
            end else if ((r_state == S_REFRESH) && mem_ack) begin
                r_mem_refresh <= 1'b0;
            end
        end
    end

    assign mem_refresh = r_mem_refresh;
`else
    logic w_unused_refresh_cfg;

    assign w_unused_refresh_cfg = (REFRESH_INTERVAL > 0);
    assign w_ref_pend           = 1'b0;
    assign mem_refresh          = 1'b0;
`endif

    assign cpu_ack   = r_cpu_ack;
    assign cpu_data  = r_cpu_data;
    assign ppu_ack   = r_ppu_ack;
    assign ppu_data  = r_ppu_data;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - directed self-checking bench for rom_port_arbiter
module tb_rom_port_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        cpu_req;
    logic [16:0] cpu_addr;
    logic        cpu_ack;
    logic [7:0]  cpu_data;
    logic        ppu_req;
    logic [16:0] ppu_addr;
    logic        ppu_ack;
    logic [7:0]  ppu_data;
    logic        mem_req;
    logic [17:0] mem_addr;
    logic        mem_refresh;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        proto_err;

    logic cpu_req_drv, ppu_req_drv, ppu_auto, model_ack, stray_ack;
    logic [7:0] model_rdata;
    int   mem_waits, mem_cnt, auto_left;
    int   grant_log[$];
    int   n_tests, n_fail;
    int   cpu_k, ppu_k, cpu_n, ppu_n;
    logic req_seen;
    logic [7:0] cpu_cap, ppu_cap;

    always #5 Clk = ~Clk;

    assign cpu_req   = cpu_req_drv;
    assign ppu_req   = ppu_req_drv | ppu_auto;
    assign mem_ack   = model_ack | stray_ack;
    assign mem_rdata = model_rdata;

    rom_port_arbiter #(
        .STARVE_MAX(4),
`ifdef ROMARB_REFRESH_EN
        .REFRESH_INTERVAL(16)
`else
        .REFRESH_INTERVAL(384)
`endif
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_data(cpu_data),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack), .ppu_data(ppu_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_refresh(mem_refresh),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .proto_err(proto_err)
    );

    // Memory: acks after mem_waits extra cycles, data = addr[7:0] ^ 8'h97.
    always @(negedge Clk) begin
        ppu_auto  = 1'b0;
        model_ack = 1'b0;
        if (mem_req || mem_refresh) begin
            if (mem_cnt >= mem_waits) begin
                model_ack   = 1'b1;
                model_rdata = mem_addr[7:0] ^ 8'h97;
                grant_log.push_back(int'({13'b0, mem_refresh, mem_addr}));
                if (!mem_refresh && mem_addr[17] && auto_left > 0) begin
                    ppu_auto  = 1'b1;
                    auto_left = auto_left - 1;
                end
                mem_cnt = 0;
            end else begin
                mem_cnt = mem_cnt + 1;
            end
        end else begin
            mem_cnt = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_window(input int n);
        cpu_k = 0; ppu_k = 0; cpu_n = 0; ppu_n = 0; req_seen = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(negedge Clk);
            cpu_req_drv = 1'b0;
            ppu_req_drv = 1'b0;
            if (cpu_ack) begin
                cpu_n++;
                if (cpu_k == 0) begin cpu_k = k; cpu_cap = cpu_data; end
            end
            if (ppu_ack) begin
                ppu_n++;
                if (ppu_k == 0) begin ppu_k = k; ppu_cap = ppu_data; end
            end
            if (mem_req) req_seen = 1'b1;
        end
    endtask

    function automatic int log_at(input int i);
        return (i < grant_log.size()) ? grant_log[i] : -1;
    endfunction

    initial begin
        int fidx, t1, t2;
        n_tests = 0; n_fail = 0;
        Reset = 1'b1; cpu_req_drv = 1'b0; ppu_req_drv = 1'b0; stray_ack = 1'b0;
        cpu_addr = 17'd0; ppu_addr = 17'd0; mem_waits = 0; mem_cnt = 0; auto_left = 0;
        model_rdata = 8'h00; model_ack = 1'b0; ppu_auto = 1'b0;
        repeat (3) @(negedge Clk);
        check_eq("rst_cpu_ack",   32'(cpu_ack),     32'd0);
        check_eq("rst_cpu_data",  32'(cpu_data),    32'd0);
        check_eq("rst_ppu_ack",   32'(ppu_ack),     32'd0);
        check_eq("rst_ppu_data",  32'(ppu_data),    32'd0);
        check_eq("rst_mem_req",   32'(mem_req),     32'd0);
        check_eq("rst_mem_addr",  32'(mem_addr),    32'd0);
        check_eq("rst_mem_ref",   32'(mem_refresh), 32'd0);
        check_eq("rst_proto_err", 32'(proto_err),   32'd0);
        Reset = 1'b0;
        @(negedge Clk);

`ifdef ROMARB_REFRESH_EN
        // T6: free-running refresh, then a cpu_req colliding with a refresh wrap
        mem_waits = 0;
        t1 = -1; t2 = -1;
        for (int k = 0; k < 80 && t2 < 0; k++) begin
            @(negedge Clk);
            if (mem_refresh && t1 < 0) t1 = k;
            else if (mem_refresh && t1 >= 0 && k > t1 + 1) t2 = k;
        end
        check_eq("t6_refresh_seen", 32'(t2 >= 0), 32'd1);
        check_eq("t6_interval", 32'(t2 - t1), 32'd16);
        repeat (14) @(negedge Clk);
        grant_log.delete();
        cpu_addr = 17'h00ABC; cpu_req_drv = 1'b1;
        run_window(20);
        check_eq("t6_first_is_ref", 32'(log_at(0)), 32'h0004_0000);
        check_eq("t6_then_cpu", 32'(log_at(1)), 32'h0000_0ABC);
        check_eq("t6_cpu_acks", 32'(cpu_n), 32'd1);
        check_eq("t6_cpu_data", 32'(cpu_cap), 32'h2B);
`else
        // T1: single CPU read, zero-wait memory
        mem_waits = 0; grant_log.delete();
        cpu_addr = 17'h1ABCD; cpu_req_drv = 1'b1;
        run_window(8);
        check_eq("t1_latency", 32'(cpu_k), 32'd3);
        check_eq("t1_acks", 32'(cpu_n), 32'd1);
        check_eq("t1_no_ppu_ack", 32'(ppu_n), 32'd0);
        check_eq("t1_data", 32'(cpu_cap), 32'h5A);
        check_eq("t1_data_hold", 32'(cpu_data), 32'h5A);
        check_eq("t1_addr", 32'(log_at(0)), 32'h0001_ABCD);
        check_eq("t1_addr_hold", 32'(mem_addr), 32'h0001_ABCD);

        // T2: simultaneous requests, 2-wait memory: PPU first
        mem_waits = 2; grant_log.delete();
        cpu_addr = 17'h0AA55; ppu_addr = 17'h00123;
        cpu_req_drv = 1'b1; ppu_req_drv = 1'b1;
        run_window(14);
        check_eq("t2_ppu_latency", 32'(ppu_k), 32'd5);
        check_eq("t2_cpu_latency", 32'(cpu_k), 32'd9);
        check_eq("t2_ppu_addr", 32'(log_at(0)), 32'h0002_0123);
        check_eq("t2_cpu_addr", 32'(log_at(1)), 32'h0000_AA55);
        check_eq("t2_ppu_data", 32'(ppu_cap), 32'hB4);
        check_eq("t2_cpu_data", 32'(cpu_cap), 32'hC2);
        check_eq("t2_acks", 32'({cpu_n[7:0], ppu_n[7:0]}), 32'h0101);

        // T3: PPU re-requests on each ack; CPU must win after 4 PPU grants
        mem_waits = 0; grant_log.delete(); auto_left = 5;
        cpu_addr = 17'h00777; ppu_addr = 17'h00100;
        cpu_req_drv = 1'b1; ppu_req_drv = 1'b1;
        run_window(40);
        fidx = -1;
        for (int i = 0; i < grant_log.size(); i++)
            if (grant_log[i][17] == 1'b0 && fidx < 0) fidx = i;
        check_eq("t3_ppu_before_cpu", 32'(fidx), 32'd4);
        check_eq("t3_cpu_addr", 32'(log_at(4)), 32'h0000_0777);
        check_eq("t3_ppu_addr", 32'(log_at(3)), 32'h0002_0100);
        check_eq("t3_cpu_acks", 32'(cpu_n), 32'd1);
        check_eq("t3_ppu_acks", 32'(ppu_n), 32'd6);
        check_eq("t3_no_proto_err", 32'(proto_err), 32'd0);

        // Stray mem_ack while idle is ignored
        stray_ack = 1'b1;
        run_window(2);
        stray_ack = 1'b0;
        run_window(3);
        check_eq("stray_no_ack", 32'(cpu_n + ppu_n), 32'd0);
        check_eq("stray_no_req", 32'(req_seen), 32'd0);

        // T4: second cpu_req before ack
        mem_waits = 2; grant_log.delete();
        cpu_addr = 17'h01234; cpu_req_drv = 1'b1;
        @(negedge Clk);
        cpu_addr = 17'h05678;
        run_window(14);
        check_eq("t4_proto_err", 32'(proto_err), 32'd1);
        check_eq("t4_one_ack", 32'(cpu_n), 32'd1);
        check_eq("t4_one_grant", 32'(grant_log.size()), 32'd1);
        check_eq("t4_orig_addr", 32'(log_at(0)), 32'h0000_1234);
        check_eq("t4_data", 32'(cpu_cap), 32'hA3);
        run_window(4);
        check_eq("t4_sticky", 32'(proto_err), 32'd1);

        // T5: reset while BUSY, with PPU also pending
        mem_waits = 20; grant_log.delete();
        cpu_addr = 17'h00042; cpu_req_drv = 1'b1;
        @(negedge Clk);
        cpu_req_drv = 1'b0; ppu_addr = 17'h00099; ppu_req_drv = 1'b1;
        @(negedge Clk);
        ppu_req_drv = 1'b0;
        check_eq("t5_busy_before", 32'(mem_req), 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        check_eq("t5_req_dropped", 32'(mem_req), 32'd0);
        check_eq("t5_proto_cleared", 32'(proto_err), 32'd0);
        Reset = 1'b0;
        run_window(30);
        check_eq("t5_no_acks", 32'(cpu_n + ppu_n), 32'd0);
        check_eq("t5_pend_cleared", 32'(req_seen), 32'd0);
        check_eq("no_refresh", 32'(mem_refresh), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
